// File: rtl/stream_manager_pkg.sv
// Shared types and constants for the stream manager:
// buffering policies, FSM states and the source-port field in tuser.
package stream_manager_pkg;

    typedef enum logic [1:0] {
        BUF_NONE   = 2'd0,
        BUF_ALL    = 2'd1,
        BUF_STREAM = 2'd3
    } buf_type_e;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        BUFFER = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int SRC_PORT_LSB   = 16;
    localparam int SRC_PORT_WIDTH = 8;

    // The unused code 2 falls back to plain pass-through
    function automatic buf_type_e decode_buf_type(input logic [1:0] t);
        case (t)
            2'd1:    return BUF_ALL;
            2'd3:    return BUF_STREAM;
            default: return BUF_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axis_ff.sv
// One-deep AXI4-Stream register slice: 1-cycle latency,
// one beat per cycle while the consumer keeps ready high.
module axis_ff #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ready_o && valid_i) begin
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/stream_manager.sv
// Routes ingress packets to egress or to an external buffer FIFO during
// a migration, then drains the buffer ahead of new ingress traffic.
module stream_manager
    import stream_manager_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,

    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]    s_axis_buf_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_buf_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   s_axis_buf_tuser,
    output logic                          s_axis_buf_tvalid,
    output logic                          s_axis_buf_tlast,
    input  logic                          s_axis_buf_tready,

    input  logic [AXIS_DATA_WIDTH-1:0]    m_axis_buf_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_buf_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   m_axis_buf_tuser,
    input  logic                          m_axis_buf_tvalid,
    input  logic                          m_axis_buf_tlast,
    output logic                          m_axis_buf_tready,

    input  logic                          migration_progress,
    output logic                          migration_ready,
    input  logic [1:0]                    buffering_type,
    input  logic [7:0]                    buffering_port
);

    localparam int KW = AXIS_DATA_WIDTH / 8;
    localparam int PW = AXIS_DATA_WIDTH + KW + AXIS_TUSER_WIDTH + 1;

    state_e    state_q, state_d;
    logic      live_q;
    logic      in_pkt_q, in_pkt_d;
    logic      route_q, route_d;
    logic      rd_pkt_q, rd_pkt_d;

    buf_type_e btype;
    logic      port_hit;
    logic      route_new;
    logic      route_buf;
    logic      switching;
    logic      active;
    logic      in_hs;
    logic      rd_hs;
    logic      draining;

    logic          m_in_ready;
    logic          b_in_ready;
    logic          m_in_valid;
    logic          b_in_valid;
    logic [PW-1:0] s_pay;
    logic [PW-1:0] rd_pay;
    logic [PW-1:0] m_in_pay;
    logic [PW-1:0] m_out_pay;
    logic [PW-1:0] b_out_pay;

    assign btype    = decode_buf_type(buffering_type);
    assign port_hit = |(s_axis_tuser[SRC_PORT_LSB +: SRC_PORT_WIDTH]
                        & buffering_port);
    assign draining = (state_q == DRAIN);

    assign route_new = (state_q == BUFFER)
                    && ((btype == BUF_ALL)
                     || ((btype == BUF_STREAM) && port_hit));
    assign route_buf = in_pkt_q ? route_q : route_new;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PASS: begin
                if (!in_pkt_q && migration_progress && btype != BUF_NONE)
                    state_d = BUFFER;
            end
            BUFFER: begin
                if (!in_pkt_q && !migration_progress)
                    state_d = DRAIN;
            end
            DRAIN: begin
                // Wait until the last buffered beat has left the write slice too
                if (!rd_pkt_q && !m_axis_buf_tvalid && !s_axis_buf_tvalid)
                    state_d = PASS;
            end
            default: state_d = PASS;
        endcase
    end

    // No new packet may start on the cycle the state changes
    assign switching = (state_d != state_q);
    assign active    = live_q && !axis_reset;

    assign s_axis_tready = active && !switching && !draining
                        && (route_buf ? b_in_ready : m_in_ready);
    assign m_axis_buf_tready = active && draining && m_in_ready;

    assign in_hs = s_axis_tvalid && s_axis_tready;
    assign rd_hs = m_axis_buf_tvalid && m_axis_buf_tready;

    assign s_pay  = {s_axis_tdata, s_axis_tkeep,
                     s_axis_tuser, s_axis_tlast};
    assign rd_pay = {m_axis_buf_tdata, m_axis_buf_tkeep,
                     m_axis_buf_tuser, m_axis_buf_tlast};

    assign m_in_valid = draining ? rd_hs : (in_hs && !route_buf);
    assign m_in_pay   = draining ? rd_pay : s_pay;
    assign b_in_valid = in_hs && route_buf;

    always_comb begin
        in_pkt_d = in_pkt_q;
        route_d  = route_q;
        rd_pkt_d = rd_pkt_q;
        if (in_hs) begin
            in_pkt_d = !s_axis_tlast;
            route_d  = route_buf;
        end
        if (rd_hs) begin
            rd_pkt_d = !m_axis_buf_tlast;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q  <= PASS;
            live_q   <= 1'b0;
            in_pkt_q <= 1'b0;
            route_q  <= 1'b0;
            rd_pkt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            in_pkt_q <= in_pkt_d;
            route_q  <= route_d;
            rd_pkt_q <= rd_pkt_d;
        end
    end

    assign migration_ready = (state_q == BUFFER) && !axis_reset;

    axis_ff #(.W(PW)) u_m_ff (
        .clk_i   (axis_aclk),
        .rst_i   (axis_reset),
        .data_i  (m_in_pay),
        .valid_i (m_in_valid),
        .ready_o (m_in_ready),
        .data_o  (m_out_pay),
        .valid_o (m_axis_tvalid),
        .ready_i (m_axis_tready)
    );

    axis_ff #(.W(PW)) u_buf_ff (
        .clk_i   (axis_aclk),
        .rst_i   (axis_reset),
        .data_i  (s_pay),
        .valid_i (b_in_valid),
        .ready_o (b_in_ready),
        .data_o  (b_out_pay),
        .valid_o (s_axis_buf_tvalid),
        .ready_i (s_axis_buf_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep,
            m_axis_tuser, m_axis_tlast} = m_out_pay;
    assign {s_axis_buf_tdata, s_axis_buf_tkeep,
            s_axis_buf_tuser, s_axis_buf_tlast} = b_out_pay;

endmodule

// File: tb/tb_stream_manager.sv
// Scoreboard bench for stream_manager with a queue-based buffer FIFO
// model between the buffer-write and buffer-read ports.
module tb_stream_manager;

    localparam int DW = 64;
    localparam int UW = 32;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic axis_reset = 1'b1;

    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;

    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;

    logic [DW-1:0] s_axis_buf_tdata;
    logic [KW-1:0] s_axis_buf_tkeep;
    logic [UW-1:0] s_axis_buf_tuser;
    logic          s_axis_buf_tvalid;
    logic          s_axis_buf_tlast;
    logic          s_axis_buf_tready = 1'b1;

    logic [DW-1:0] m_axis_buf_tdata = '0;
    logic [KW-1:0] m_axis_buf_tkeep = '0;
    logic [UW-1:0] m_axis_buf_tuser = '0;
    logic          m_axis_buf_tvalid = 1'b0;
    logic          m_axis_buf_tlast = 1'b0;
    logic          m_axis_buf_tready;

    logic       migration_progress = 1'b0;
    logic       migration_ready;
    logic [1:0] buffering_type = 2'd0;
    logic [7:0] buffering_port = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pid = 0;
    bit bp = 1'b0;
    bit bpw = 1'b0;

    exp_t exp_m[$];
    exp_t exp_buf[$];
    exp_t pending[$];
    logic [DW+KW+UW:0] fifo[$];

    stream_manager #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW)
    ) dut (
        .axis_aclk          (clk),
        .axis_reset         (axis_reset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tuser       (m_axis_tuser),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tready      (m_axis_tready),
        .s_axis_buf_tdata   (s_axis_buf_tdata),
        .s_axis_buf_tkeep   (s_axis_buf_tkeep),
        .s_axis_buf_tuser   (s_axis_buf_tuser),
        .s_axis_buf_tvalid  (s_axis_buf_tvalid),
        .s_axis_buf_tlast   (s_axis_buf_tlast),
        .s_axis_buf_tready  (s_axis_buf_tready),
        .m_axis_buf_tdata   (m_axis_buf_tdata),
        .m_axis_buf_tkeep   (m_axis_buf_tkeep),
        .m_axis_buf_tuser   (m_axis_buf_tuser),
        .m_axis_buf_tvalid  (m_axis_buf_tvalid),
        .m_axis_buf_tlast   (m_axis_buf_tlast),
        .m_axis_buf_tready  (m_axis_buf_tready),
        .migration_progress (migration_progress),
        .migration_ready    (migration_ready),
        .buffering_type     (buffering_type),
        .buffering_port     (buffering_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer FIFO model (stands in for axis_fifo)
    always @(posedge clk) begin
        if (axis_reset) begin
            fifo.delete();
            m_axis_buf_tvalid <= 1'b0;
        end else begin
            if (m_axis_buf_tvalid && m_axis_buf_tready)
                void'(fifo.pop_front());
            if (s_axis_buf_tvalid && s_axis_buf_tready && fifo.size() < 65536)
                fifo.push_back({s_axis_buf_tdata, s_axis_buf_tkeep,
                                s_axis_buf_tuser, s_axis_buf_tlast});
            m_axis_buf_tvalid <= (fifo.size() != 0);
            if (fifo.size() != 0)
                {m_axis_buf_tdata, m_axis_buf_tkeep,
                 m_axis_buf_tuser, m_axis_buf_tlast} <= fifo[0];
        end
    end

    initial forever begin
        @(negedge clk);
        m_axis_tready     = bp  ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_buf_tready = bpw ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [127:0] pk(input exp_t e);
        return {23'b0, e.data, e.keep, e.user, e.last};
    endfunction

    function automatic void chk(input string name,
                                input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input int p, input int i, input int len,
                                input logic [7:0] src);
        exp_t e;
        e.data = {p[31:0], i[31:0]};
        e.last = (i == len - 1);
        e.keep = e.last ? 8'h0F : 8'hFF;
        e.user = {8'hA5, src, p[15:0]};
        e.cyc  = -1;
        return e;
    endfunction

    logic [127:0] cur_m, cur_b;
    assign cur_m = {23'b0, m_axis_tdata, m_axis_tkeep,
                    m_axis_tuser, m_axis_tlast};
    assign cur_b = {23'b0, s_axis_buf_tdata, s_axis_buf_tkeep,
                    s_axis_buf_tuser, s_axis_buf_tlast};

    // Monitor: pops expectations whenever a beat is taken on either output
    initial begin
        exp_t e;
        bit m_hold;
        logic [127:0] m_held;
        m_hold = 1'b0;
        m_held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (axis_reset) begin
                m_hold = 1'b0;
            end else begin
                if (m_hold) begin
                    chk("m_hold_valid", 128'(m_axis_tvalid), 128'(1));
                    chk("m_hold_data", cur_m, m_held);
                end
                m_hold = m_axis_tvalid && !m_axis_tready;
                m_held = cur_m;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_m.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL m_unexpected got %h want none", cur_m);
                    end else begin
                        e = exp_m.pop_front();
                        chk("m_beat", cur_m, pk(e));
                        if (e.cyc >= 0)
                            chk("m_latency", 128'(cyc), 128'(e.cyc));
                    end
                end
                if (s_axis_buf_tvalid && s_axis_buf_tready) begin
                    if (exp_buf.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL buf_unexpected got %h want none", cur_b);
                    end else begin
                        e = exp_buf.pop_front();
                        chk("buf_beat", cur_b, pk(e));
                        if (e.cyc >= 0)
                            chk("buf_latency", 128'(cyc), 128'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic send_beat(input exp_t b, input bit to_buf, input bit lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        #1;
        while (!s_axis_tready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL in_stall_timeout got no ready want ready beat %h", b.data);
            s_axis_tvalid = 1'b0;
            return;
        end
        e = b;
        e.cyc = lat ? cyc + 1 : -1;
        if (to_buf) begin
            exp_buf.push_back(e);
            e.cyc = -1;
            pending.push_back(e);
        end else begin
            exp_m.push_back(e);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] src,
                            input bit to_buf, input bit lat);
        int p;
        p = pid;
        pid++;
        for (int i = 0; i < len; i++)
            send_beat(mk(p, i, len, src), to_buf, lat);
    endtask

    task automatic release_pending();
        while (pending.size() != 0)
            exp_m.push_back(pending.pop_front());
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_m.size() != 0 || exp_buf.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout left m %0d buf %0d want 0 0",
                     exp_m.size(), exp_buf.size());
            exp_m.delete();
            exp_buf.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_tvalid"},   128'(m_axis_tvalid), 128'(0));
        chk({tag, "_buf_tvalid"}, 128'(s_axis_buf_tvalid), 128'(0));
        chk({tag, "_s_tready"},   128'(s_axis_tready), 128'(0));
        chk({tag, "_rd_tready"},  128'(m_axis_buf_tready), 128'(0));
        chk({tag, "_mready"},     128'(migration_ready), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_quiet("rst");
        axis_reset = 1'b0;
        #1;
        chk_quiet("post_rst");

        // Plain pass-through even with a migration request
        @(negedge clk);
        buffering_type = 2'd0;
        migration_progress = 1'b1;
        for (int i = 0; i < 10; i++)
            send_pkt(i % 4 + 1, 8'h02, 1'b0, 1'b1);
        wait_idle();
        chk("none_mready", 128'(migration_ready), 128'(0));

        // Code 2 behaves like BUF_NONE
        @(negedge clk);
        buffering_type = 2'd2;
        send_pkt(2, 8'h02, 1'b0, 1'b1);
        send_pkt(1, 8'h02, 1'b0, 1'b1);
        wait_idle();
        chk("type2_mready", 128'(migration_ready), 128'(0));

        // Short request pulse inside one packet: no state change
        @(negedge clk);
        buffering_type = 2'd1;
        migration_progress = 1'b0;
        fork
            send_pkt(6, 8'h02, 1'b0, 1'b1);
            begin
                repeat (2) @(negedge clk);
                migration_progress = 1'b1;
                @(negedge clk);
                migration_progress = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("pulse_mready", 128'(migration_ready), 128'(0));
        wait_idle();

        // BUF_ALL: everything buffered, then drained ahead of new traffic
        @(negedge clk);
        migration_progress = 1'b1;
        repeat (3) @(negedge clk);
        chk("all_mready", 128'(migration_ready), 128'(1));
        for (int i = 0; i < 5; i++)
            send_pkt(i % 3 + 1, 8'h02, 1'b1, 1'b1);
        wait_idle();
        chk("all_mready_hold", 128'(migration_ready), 128'(1));
        chk("all_fifo_beats", 128'(fifo.size()), 128'(9));
        @(negedge clk);
        migration_progress = 1'b0;
        release_pending();
        @(negedge clk);
        #1;
        chk("drain_mready", 128'(migration_ready), 128'(0));
        for (int i = 0; i < 3; i++)
            send_pkt(2, 8'h02, 1'b0, 1'b0);
        wait_idle();

        // BUF_STREAM: only source port 0 is diverted
        @(negedge clk);
        buffering_type = 2'd3;
        buffering_port = 8'h01;
        migration_progress = 1'b1;
        repeat (3) @(negedge clk);
        chk("stream_mready", 128'(migration_ready), 128'(1));
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                send_pkt(i % 3 + 1, 8'h01, 1'b1, 1'b1);
            else
                send_pkt(i % 3 + 1, 8'h04, 1'b0, 1'b1);
        end
        send_pkt(2, 8'h05, 1'b1, 1'b1);
        wait_idle();
        @(negedge clk);
        migration_progress = 1'b0;
        release_pending();
        wait_idle();
        chk("stream_end_mready", 128'(migration_ready), 128'(0));

        // Random backpressure on egress and buffer write
        @(negedge clk);
        bp = 1'b1;
        bpw = 1'b1;
        buffering_type = 2'd0;
        migration_progress = 1'b1;
        for (int i = 0; i < 10; i++)
            send_pkt(i % 4 + 1, 8'h02, 1'b0, 1'b0);
        wait_idle();
        @(negedge clk);
        buffering_type = 2'd1;
        for (int i = 0; i < 4; i++)
            send_pkt(i % 4 + 1, 8'h02, 1'b1, 1'b0);
        wait_idle();
        @(negedge clk);
        migration_progress = 1'b0;
        release_pending();
        wait_idle();
        bp = 1'b0;
        bpw = 1'b0;

        // Reset in the middle of a buffered packet
        @(negedge clk);
        buffering_type = 2'd1;
        migration_progress = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_pre_mready", 128'(migration_ready), 128'(1));
        send_beat(mk(pid, 0, 4, 8'h02), 1'b1, 1'b0);
        send_beat(mk(pid, 1, 4, 8'h02), 1'b1, 1'b0);
        pid++;
        @(negedge clk);
        axis_reset = 1'b1;
        migration_progress = 1'b0;
        buffering_type = 2'd0;
        @(negedge clk);
        #1;
        chk_quiet("rstmid");
        axis_reset = 1'b0;
        #1;
        chk_quiet("rstmid_post");
        exp_m.delete();
        exp_buf.delete();
        pending.delete();
        send_pkt(3, 8'h02, 1'b0, 1'b1);
        send_pkt(1, 8'h02, 1'b0, 1'b1);
        wait_idle();
        chk("final_mready", 128'(migration_ready), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_manager.md
STREAM_MANAGER -- requirements
Module: stream_manager

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 512, SHALL set the tdata width; tkeep width SHALL be AXIS_DATA_WIDTH/8.
REQ-002 Parameter AXIS_TUSER_WIDTH, default 256, SHALL set the tuser width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, on the following two ports.
- axis_aclk  in  1  sole clock; all logic on the rising edge.
- axis_reset  in  1  synchronous, active-high reset.
REQ-004 Ingress bundle, AXI4-Stream slave: s_axis_tdata/tkeep/tuser/tvalid/tlast in, s_axis_tready out.
REQ-005 Egress bundle, AXI4-Stream master: m_axis_tdata/tkeep/tuser/tvalid/tlast out, m_axis_tready in.
REQ-006 Buffer-write bundle, master to external FIFO: s_axis_buf_tdata/tkeep/tuser/tvalid/tlast out, s_axis_buf_tready in.
REQ-007 Buffer-read bundle, slave from external FIFO: m_axis_buf_tdata/tkeep/tuser/tvalid/tlast in, m_axis_buf_tready out.
REQ-008 Control ports:
- migration_progress  in  1  request to divert traffic.
- migration_ready  out  1  diversion active.
- buffering_type  in  2  diversion policy.
- buffering_port  in  8  source-port mask.

Function
REQ-009 buffering_type encoding SHALL be: 0 = BUF_NONE, 1 = BUF_ALL, 3 = BUF_STREAM. Value 2 SHALL be treated as BUF_NONE.
REQ-010 The state machine SHALL have three states: PASS, BUFFER, DRAIN. Transitions SHALL occur only at packet boundaries, i.e. no ingress or egress packet is partially transferred.
REQ-011 PASS -> BUFFER SHALL occur when migration_progress=1 and buffering_type is not BUF_NONE.
REQ-012 BUFFER -> DRAIN SHALL occur when migration_progress=0.
REQ-013 DRAIN -> PASS SHALL occur at a buffer-read packet boundary where m_axis_buf_tvalid=0.
REQ-014 Each ingress packet's route SHALL be decided on its first beat and held through its tlast beat.
- In BUFFER, a packet SHALL be routed to the buffer when buffering_type=BUF_ALL.
- In BUFFER with BUF_STREAM, a packet SHALL be routed to the buffer when (s_axis_tuser[23:16] & buffering_port) != 0.
- All other packets SHALL be routed to egress.
REQ-015 In PASS and BUFFER, s_axis_tready SHALL follow the readiness of the selected destination.
REQ-016 In DRAIN, s_axis_tready SHALL be 0, and egress SHALL be sourced from the buffer-read bundle. This keeps per-flow order.
REQ-017 tdata, tkeep, tuser and tlast SHALL pass unmodified on every path.
REQ-018 m_axis and s_axis_buf outputs SHALL each be driven through a register slice.
- Latency: 1 cycle.
- Full throughput: one beat per cycle under continuous tready.
- A beat SHALL never be dropped or duplicated under tready backpressure.
REQ-019 migration_ready SHALL be 1 exactly while the state is BUFFER.
REQ-020 If migration_progress toggles mid-packet, the change SHALL take effect only at the next boundary. A pulse shorter than one packet that has ended by then SHALL cause no state change.
REQ-021 If the buffer-write interface backpressures (s_axis_buf_tready=0), ingress SHALL stall and SHALL not spill to egress.

Reset
REQ-022 On reset, the block SHALL enter state PASS and clear route state. m_axis_tvalid, s_axis_buf_tvalid, m_axis_buf_tready, s_axis_tready and migration_ready SHALL be 0 during reset and on the first cycle after it. In-flight data SHALL be discarded.

Structure
REQ-023 A shared package SHALL hold BUF_NONE/BUF_ALL/BUF_STREAM, the state encoding, and SRC_PORT_LSB=16 / SRC_PORT_WIDTH=8.
REQ-024 The register slice SHALL be one sub-module, axis_ff, instantiated twice. The buffer FIFO is external (axis_fifo).

Verification
REQ-025 A bench SHALL cover the following directed scenarios, with an axis_fifo (depth 2^16) connected between the buffer ports:
- BUF_NONE, migration_progress=1, 10 packets -> all 10 on m_axis in order, 1-cycle latency; migration_ready=0.
- BUF_ALL, migration_progress=1 -> migration_ready=1 at the next boundary; m_axis_tvalid stays 0; all beats enter the FIFO.
- BUF_STREAM, buffering_port=8'h01, packets alternating tuser[23:16]=8'h01/8'h04 -> 8'h04 packets on m_axis; 8'h01 packets buffered.
- migration_progress 1 -> 0 after 5 buffered packets -> those 5 emerge on m_axis first, in order, then ingress resumes; final order is the original order.
- m_axis_tready random 50% -> data file identical to the no-backpressure run; no tvalid drop mid-packet.
- Reset asserted mid-packet in BUFFER -> next cycle state PASS, migration_ready=0, all tvalid outputs 0.
